aes_round_ctrl: RTL and testbench
=================================

# aes_round_ctrl

Sequencer for the AES-128 encryption datapath: it holds the 128-bit state register and drives the combinational round transforms (subbytes, shiftrows, mixcolumns, addroundkey) for ten rounds. It uses one round per clock and a start/done handshake. It sits between the top-level I/O wrapper and the external key-schedule block, which returns the round key for the round index this block presents.

## Interface
- No parameters. Nr = 10 and the 128-bit width are fixed constants (see Structure).
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high; one clock, synchronous reset active-high.
- start  input  1  request to encrypt `plaintext`; sampled only in IDLE or DONE.
- plaintext  input  [15:0][7:0]  input block; byte [15] is FIPS-197 input byte 0, matching the shiftrows byte order.
- round_key  input  [15:0][7:0]  round key for `round_idx`, supplied combinationally in the same cycle by the key schedule.
- round_idx  output  4  round whose key is needed this cycle (0..10).
- busy  output  1  high while rounds are executing.
- done  output  1  one-cycle pulse when `ciphertext` becomes valid.
- ciphertext  output  [15:0][7:0]  result; held stable until the next accepted start.

## Operation
- FSM states are IDLE, RUN and DONE.
- IDLE:
  - round_idx = 0.
  - On start: state_q <= plaintext ^ round_key (rk0), round_q <= 1, go to RUN.
- RUN, with round_q in 1..9:
  - state_q <= mixcolumns(shiftrows(subbytes(state_q))) ^ round_key.
  - round_q <= round_q + 1.
- RUN, with round_q == 10 (final round, mixcolumns skipped):
  - state_q <= shiftrows(subbytes(state_q)) ^ round_key.
  - Go to DONE.
- DONE:
  - done = 1 for exactly this cycle.
  - ciphertext = state_q.
  - Next state is IDLE. A start seen in DONE is accepted exactly as in IDLE, so back-to-back blocks are possible.
- round_idx = round_q in RUN and 0 in IDLE/DONE. The round counter is 4 bits and never exceeds 10. No wrap occurs, because RUN exits at 10.
- busy = 1 only in RUN.
- start while busy is ignored. It is not queued and does not disturb the operation in flight.
- plaintext is sampled only on the accepting edge. Later changes have no effect.
- ciphertext register: loaded from state_q on entry to DONE, then held through IDLE.

## Timing
- Reset values:
  - FSM in IDLE.
  - round_q = 0, state_q = 0, ciphertext = 0.
  - busy = 0, done = 0, round_idx = 0.
- Latency: start sampled at edge E0 → RUN for rounds 1..10 on edges E1..E10 → done high in the cycle after E10. That is 11 cycles from start to done.
- Throughput: one block every 11 cycles when start is held high continuously.
- Reset asserted mid-operation:
  - Abort on that edge and return to IDLE with the reset values above.
  - No done pulse is produced.
  - ciphertext is cleared to 0.
- Reset and start high in the same cycle: reset wins.
- round_key must be valid combinationally for the round_idx presented in the same cycle. There is no registered key path.

## Configuration
- AES_SINGLE_STEP_EN, when defined:
  - Adds input `step` (1 bit).
  - In RUN, a round executes only on cycles where step = 1. Otherwise state_q, round_q and the FSM hold.
  - The IDLE → RUN load and the DONE pulse are not gated by step.
  - Used for round-by-round debug against FIPS-197 intermediate values.
- Undefined: no `step` port, and a round executes every RUN cycle.

## Structure
- Shared package aes_pkg holds:
  - the state typedef `logic [15:0][7:0]` (state_t);
  - NR = 10;
  - the FSM enum (IDLE, RUN, DONE).
- Sub-module aes_round_datapath is combinational:
  - inputs state, round_key and a `final` flag;
  - output is the next state;
  - it instantiates the existing subbytes, shiftrows and mixcolumns modules;
  - `final` bypasses mixcolumns.
- aes_round_ctrl contains only the FSM, the round counter, state_q and the ciphertext register.

## Test plan
- Reset, then idle for 5 cycles → busy = 0, done = 0, round_idx = 0, ciphertext = 0 throughout.
- FIPS-197 App. B:
  - Stimulus: plaintext 3243f6a8885a308d313198a2e0370734, key 2b7e151628aed2a6abf7158809cf4f3c, with a key-schedule model on round_key.
  - Expect: state_q = 193de3bea0f4e22b9ac68d2ae9f84808 after E0.
  - Expect: done exactly 11 cycles after start, with ciphertext 3925841d02dc09fbdc118597196a0b32.
- round_idx sequence: for one operation, round_idx is 0 in IDLE, then 1, 2, … 10 on consecutive RUN cycles, then 0 in DONE.
- Start while busy:
  - Stimulus: pulse start at round 4 with a different plaintext.
  - Expect: the result is still 3925841d…0b32, and no second done pulse appears.
- Back-to-back: start held high for 2 blocks → done pulses 11 cycles apart, and both ciphertexts are correct.
- Reset mid-operation:
  - Stimulus: assert reset at round 6 for one cycle.
  - Expect: FSM in IDLE, ciphertext = 0, and no done pulse.
  - A following start produces the correct ciphertext.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared types and GF(2^8) helpers for the AES-128 round sequencer.
// Holds the state type, round count, FSM encoding and field arithmetic.
package aes_pkg;

  typedef logic [15:0][7:0] state_t;

  localparam int NR = 10;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } fsm_t;

  function automatic logic [7:0] xtime(
    input logic [7:0] a
  );
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(
    input logic [7:0] a,
    input logic [7:0] b
  );
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

endpackage

// File: rtl/aes_round_datapath.sv
// One combinational AES round: subbytes, shiftrows, mixcolumns, key add.
// Ports: state, round_key, last_round (skips mixcolumns) -> next_state.
module aes_round_datapath
  import aes_pkg::*;
(
  input  state_t state,
  input  state_t round_key,
  input  logic   last_round,
  output state_t next_state
);

  state_t sb;
  state_t sr;
  state_t mc;

  subbytes u_sb (
    .state  (state),
    .result (sb)
  );

  shiftrows u_sr (
    .state  (sb),
    .result (sr)
  );

  mixcolumns u_mc (
    .state  (sr),
    .result (mc)
  );

  assign next_state = (last_round ? sr : mc) ^ round_key;

endmodule

// File: rtl/mixcolumns.sv
// AES MixColumns over the four state columns.
// Ports: state in, result out; purely combinational.
module mixcolumns
  import aes_pkg::*;
(
  input  state_t state,
  output state_t result
);

  always_comb begin
    result = '0;
    for (int c = 0; c < 4; c++) begin
      result[15 - 4 * c] =
        xtime(state[15 - 4 * c])
        ^ xtime(state[14 - 4 * c])
        ^ state[14 - 4 * c]
        ^ state[13 - 4 * c]
        ^ state[12 - 4 * c];
      result[14 - 4 * c] =
        state[15 - 4 * c]
        ^ xtime(state[14 - 4 * c])
        ^ xtime(state[13 - 4 * c])
        ^ state[13 - 4 * c]
        ^ state[12 - 4 * c];
      result[13 - 4 * c] =
        state[15 - 4 * c]
        ^ state[14 - 4 * c]
        ^ xtime(state[13 - 4 * c])
        ^ xtime(state[12 - 4 * c])
        ^ state[12 - 4 * c];
      result[12 - 4 * c] =
        xtime(state[15 - 4 * c])
        ^ state[15 - 4 * c]
        ^ state[14 - 4 * c]
        ^ state[13 - 4 * c]
        ^ xtime(state[12 - 4 * c]);
    end
  end

endmodule

// File: rtl/shiftrows.sv
// AES ShiftRows; byte [15] is FIPS byte 0 (row 0, column 0).
// Ports: state in, result out; purely combinational.
module shiftrows
  import aes_pkg::*;
(
  input  state_t state,
  output state_t result
);

  // FIPS byte n = r + 4c lives at packed index 15 - n.
  always_comb begin
    result = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        result[15 - (r + 4 * c)] =
          state[15 - (r + 4 * ((c + r) % 4))];
      end
    end
  end

endmodule

// File: rtl/subbytes.sv
// AES SubBytes on all 16 bytes of the state.
// Ports: state in, result out; purely combinational.
module subbytes
  import aes_pkg::*;
(
  input  state_t state,
  output state_t result
);

  // Multiplicative inverse as x^254, then the affine map.
  function automatic logic [7:0] sbox(
    input logic [7:0] x
  );
    logic [7:0] r;
    logic [7:0] p;
    r = 8'h01;
    p = x;
    for (int i = 1; i < 8; i++) begin
      p = gf_mul(p, p);
      r = gf_mul(r, p);
    end
    return r
      ^ {r[6:0], r[7]}
      ^ {r[5:0], r[7:6]}
      ^ {r[4:0], r[7:5]}
      ^ {r[3:0], r[7:4]}
      ^ 8'h63;
  endfunction

  always_comb begin
    result = '0;
    for (int i = 0; i < 16; i++) begin
      result[i] = sbox(state[i]);
    end
  end

endmodule

// File: rtl/aes_round_ctrl.sv
// AES-128 round sequencer: state register, round counter, ciphertext reg.
// Ports: clk, reset (sync, active-high), start, plaintext, round_key in;
// round_idx, busy, done, ciphertext out. Macro AES_SINGLE_STEP_EN adds
// a step input that gates each RUN round for debug stepping.
module aes_round_ctrl
  import aes_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
`ifdef AES_SINGLE_STEP_EN
  input  logic       step,
`endif
  input  state_t     plaintext,
  input  state_t     round_key,
  output logic [3:0] round_idx,
  output logic       busy,
  output logic       done,
  output state_t     ciphertext
);

  fsm_t       fsm_q;
  fsm_t       fsm_d;
  logic [3:0] round_q;
  logic [3:0] round_d;
  state_t     state_q;
  state_t     state_d;
  state_t     ct_q;
  state_t     ct_d;
  state_t     dp_out;
  logic       last;
  logic       adv;

`ifdef AES_SINGLE_STEP_EN
  assign adv = step;
`else
  assign adv = 1'b1;
`endif

  assign last = (round_q == 4'(NR));

  aes_round_datapath u_dp (
    .state      (state_q),
    .round_key  (round_key),
    .last_round (last),
    .next_state (dp_out)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      fsm_q   <= IDLE;
      round_q <= '0;
      state_q <= '0;
      ct_q    <= '0;
    end else begin
      fsm_q   <= fsm_d;
      round_q <= round_d;
      state_q <= state_d;
      ct_q    <= ct_d;
    end
  end

  always_comb begin
    fsm_d     = fsm_q;
    round_d   = round_q;
    state_d   = state_q;
    ct_d      = ct_q;
    busy      = 1'b0;
    done      = 1'b0;
    round_idx = '0;
    unique case (fsm_q)
      IDLE: begin
        if (start) begin
          state_d = plaintext ^ round_key;
          round_d = 4'd1;
          fsm_d   = RUN;
        end
      end
      RUN: begin
        busy      = 1'b1;
        round_idx = round_q;
        if (adv) begin
          state_d = dp_out;
          if (last) begin
            ct_d    = dp_out;
            round_d = '0;
            fsm_d   = DONE;
          end else begin
            round_d = round_q + 4'd1;
          end
        end
      end
      DONE: begin
        done  = 1'b1;
        fsm_d = IDLE;
        // Accepting here allows back-to-back blocks.
        if (start) begin
          state_d = plaintext ^ round_key;
          round_d = 4'd1;
          fsm_d   = RUN;
        end
      end
      default: begin
        fsm_d = IDLE;
      end
    endcase
  end

  assign ciphertext = ct_q;

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Self-checking bench for aes_round_ctrl using FIPS-197 / SP800-38A
// vectors with a round-key table indexed by round_idx.
module tb_aes_round_ctrl;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic [127:0] plaintext = '0;
  logic [127:0] round_key;
  logic [3:0]   round_idx;
  logic         busy;
  logic         done;
  logic [127:0] ciphertext;
`ifdef AES_SINGLE_STEP_EN
  logic         step = 1'b1;
`endif

  logic [127:0] rk_tab [0:10];

  typedef struct {
    logic [127:0] pt;
    logic [127:0] ct;
  } vec_t;

  vec_t vecs [3];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  assign round_key =
    (round_idx <= 4'd10) ? rk_tab[round_idx] : '0;

  aes_round_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
`ifdef AES_SINGLE_STEP_EN
    .step       (step),
`endif
    .plaintext  (plaintext),
    .round_key  (round_key),
    .round_idx  (round_idx),
    .busy       (busy),
    .done       (done),
    .ciphertext (ciphertext)
  );

  task automatic chk(
    input string        name,
    input logic [127:0] act,
    input logic [127:0] exp
  );
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chki(
    input string name,
    input int    act,
    input int    exp
  );
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!done && n < 40);
  endtask

  task automatic wait_idx(input int k);
    int n;
    n = 0;
    while (int'(round_idx) != k && n < 40) begin
      tick();
      n++;
    end
    chki("reach_round_idx", int'(round_idx), k);
  endtask

  task automatic run_block(
    input logic [127:0] pt,
    input logic [127:0] ct,
    input bit           chk_rk0
  );
    int n;
    chki("idle_round_idx", int'(round_idx), 0);
    plaintext = pt;
    start = 1'b1;
    tick();
    start = 1'b0;
    plaintext = 128'hdeadbeef_cafef00d_01234567_89abcdef;
    if (chk_rk0) begin
      chk("state_after_rk0", dut.state_q,
          128'h193de3bea0f4e22b9ac68d2ae9f84808);
    end
    n = 1;
    while (!done && n < 40) begin
      chki("run_round_idx", int'(round_idx), n);
      chki("run_busy", int'(busy), 1);
      tick();
      n++;
    end
    chki("latency", n, 11);
    chki("done_pulse", int'(done), 1);
    chk("ciphertext", ciphertext, ct);
    chki("done_round_idx", int'(round_idx), 0);
    chki("done_busy", int'(busy), 0);
    tick();
    chki("done_drops", int'(done), 0);
    chk("ct_held", ciphertext, ct);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    int cnt;

    rk_tab[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    rk_tab[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
    rk_tab[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
    rk_tab[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
    rk_tab[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
    rk_tab[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
    rk_tab[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
    rk_tab[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
    rk_tab[8]  = 128'head27321b58dbad2312bf5607f8d292f;
    rk_tab[9]  = 128'hac7766f319fadc2128d12941575c006e;
    rk_tab[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

    vecs[0] = '{pt: 128'h3243f6a8885a308d313198a2e0370734,
                ct: 128'h3925841d02dc09fbdc118597196a0b32};
    vecs[1] = '{pt: 128'h6bc1bee22e409f96e93d7e117393172a,
                ct: 128'h3ad77bb40d7a3660a89ecaf32466ef97};
    vecs[2] = '{pt: 128'hae2d8a571e03ac9c9eb76fac45af8e51,
                ct: 128'hf5d3d58503b9699de785895a96fdbaaf};

    // reset wins over a simultaneous start
    start = 1'b1;
    plaintext = vecs[0].pt;
    tick();
    tick();
    chki("rst_start_busy", int'(busy), 0);
    chki("rst_start_idx", int'(round_idx), 0);
    start = 1'b0;
    reset = 1'b0;

    for (int i = 0; i < 5; i++) begin
      tick();
      chki("idle_busy", int'(busy), 0);
      chki("idle_done", int'(done), 0);
      chki("idle_idx", int'(round_idx), 0);
      chk("idle_ct", ciphertext, '0);
    end

    for (int i = 0; i < 3; i++) begin
      run_block(vecs[i].pt, vecs[i].ct, i == 0);
    end

    // start while busy is ignored
    plaintext = vecs[0].pt;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_idx(4);
    plaintext = vecs[1].pt;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(n);
    chki("busy_start_done", int'(done), 1);
    chk("busy_start_ct", ciphertext, vecs[0].ct);
    cnt = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (done) cnt++;
    end
    chki("busy_start_no_2nd_done", cnt, 0);

    // back-to-back with start held high
    plaintext = vecs[1].pt;
    start = 1'b1;
    tick();
    wait_done(n);
    chki("b2b_lat1", n + 1, 11);
    chk("b2b_ct1", ciphertext, vecs[1].ct);
    plaintext = vecs[2].pt;
    wait_done(n);
    chki("b2b_spacing", n, 11);
    chk("b2b_ct2", ciphertext, vecs[2].ct);
    start = 1'b0;
    tick();
    chki("b2b_end_done", int'(done), 0);
    chki("b2b_end_busy", int'(busy), 0);

    // reset mid-operation
    plaintext = vecs[0].pt;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_idx(6);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chki("midrst_busy", int'(busy), 0);
    chki("midrst_idx", int'(round_idx), 0);
    chki("midrst_done", int'(done), 0);
    chk("midrst_ct", ciphertext, '0);
    chk("midrst_state", dut.state_q, '0);
    cnt = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (done) cnt++;
    end
    chki("midrst_no_done", cnt, 0);
    run_block(vecs[0].pt, vecs[0].ct, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
